burst_line_adaptor: RTL and testbench

//  Parametrised bridge between the last-level cache (one LINE_W-bit line per request) and main memory (BEATS bursts of BURST_W bits).

---
 rtl/burst_line_adaptor.sv | 176 +++++++++++++++++
 tb/tb_burst_line_adaptor.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_line_adaptor.sv
// burst_line_adaptor
//   Bridges a cache that moves one LINE_W-bit line per request to a memory port
//   that moves BEATS = LINE_W/BURST_W beats of BURST_W bits. A read gathers the
//   beats into line_o. A write splits the latched line onto burst_o. One
//   transaction runs at a time: IDLE -> XFER -> DONE -> IDLE.
//
//   Optional feature: define CRITICAL_WORD_FIRST_EN for critical-word-first beat
//   ordering. The first beat is the one holding the requested address, and the
//   rest follow in wrap order. Without the macro, beats run 0..BEATS-1 and the
//   memory address is fully line-aligned.
//
// Ports
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   line_i                  write line from cache, latched when the request is taken
//   line_o                  assembled read line (registered)
//   address_i               request byte address
//   read_i / write_i        level requests held until resp_o; write_i wins
//   resp_o                  one-cycle completion pulse to cache
//   busy_o                  transaction in flight (XFER or DONE)
//   burst_i                 read beat from memory
//   burst_o                 write beat to memory (registered)
//   address_o               memory address (registered)
//   read_o / write_o        memory strobes, held for the whole transfer
//   resp_i                  memory beat acknowledge
module burst_line_adaptor #(
   parameter int unsigned LINE_W  = 256,
   parameter int unsigned BURST_W = 64,
   parameter int unsigned ADDR_W  = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [LINE_W-1:0]  line_i,
   output logic [LINE_W-1:0]  line_o,
   input  logic [ADDR_W-1:0]  address_i,
   input  logic               read_i,
   input  logic               write_i,
   output logic               resp_o,
   output logic               busy_o,
   input  logic [BURST_W-1:0] burst_i,
   output logic [BURST_W-1:0] burst_o,
   output logic [ADDR_W-1:0]  address_o,
   output logic               read_o,
   output logic               write_o,
   input  logic               resp_i
);

   localparam int unsigned BEATS  = LINE_W / BURST_W;
   localparam int unsigned CNT_W  = $clog2(BEATS);
   localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
   localparam int unsigned BOFF_W = $clog2(BURST_W / 8);
`ifdef CRITICAL_WORD_FIRST_EN
   localparam int unsigned ALIGN_W = BOFF_W;
`else
   localparam int unsigned ALIGN_W = OFF_W;
`endif
   localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << ALIGN_W;

   // Reject geometries where the line is not a power-of-two number (>= 2) of beats.
   if ((LINE_W % BURST_W) != 0 || BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : g_bad_geometry
      $error("burst_line_adaptor: LINE_W/BURST_W must be a power of two >= 2");
   end

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

   state_t state_q, state_d;

   logic                            op_write_q, op_write_d;
   logic [BEATS-1:0][BURST_W-1:0]   wline_q, wline_d;
   logic [BEATS-1:0][BURST_W-1:0]   rline_q, rline_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic [CNT_W-1:0]                start_q, start_d;
   logic [CNT_W-1:0]                idx_q, idx_d;
   logic [ADDR_W-1:0]               addr_d;
   logic [BURST_W-1:0]              burst_d;
   logic                            read_d, write_d, resp_d, busy_d;

   // The beat index wraps naturally in CNT_W bits, which gives the wrap order.
   assign idx_q  = start_q + cnt_q;
   assign line_o = rline_q;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (write_i || read_i) state_d = S_XFER;
         S_XFER:  if (resp_i && cnt_q == CNT_W'(BEATS - 1)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output and datapath next values. Outputs are computed from the next state
   // so that they are registered and line up with the state they describe.
   always_comb begin
      op_write_d = op_write_q;
      wline_d    = wline_q;
      rline_d    = rline_q;
      cnt_d      = cnt_q;
      start_d    = start_q;
      addr_d     = address_o;
      idx_d      = '0;
      read_d     = 1'b0;
      write_d    = 1'b0;
      resp_d     = 1'b0;
      busy_d     = 1'b0;
      burst_d    = '0;

      case (state_q)
         S_IDLE: begin
            if (write_i || read_i) begin
               op_write_d = write_i;
               wline_d    = line_i;
               cnt_d      = '0;
               addr_d     = address_i & ADDR_MASK;
`ifdef CRITICAL_WORD_FIRST_EN
               start_d    = CNT_W'(address_i >> BOFF_W);
`else
               start_d    = '0;
`endif
            end
         end
         S_XFER: begin
            if (resp_i) begin
               if (!op_write_q) rline_d[idx_q] = burst_i;
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase

      idx_d  = start_d + cnt_d;
      busy_d = (state_d != S_IDLE);
      resp_d = (state_d == S_DONE);
      if (state_d == S_XFER) begin
         read_d  = !op_write_d;
         write_d = op_write_d;
         if (op_write_d) burst_d = wline_d[idx_d];
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_write_q <= 1'b0;
         wline_q    <= '0;
         rline_q    <= '0;
         cnt_q      <= '0;
         start_q    <= '0;
         address_o  <= '0;
         burst_o    <= '0;
         read_o     <= 1'b0;
         write_o    <= 1'b0;
         resp_o     <= 1'b0;
         busy_o     <= 1'b0;
      end else begin
         op_write_q <= op_write_d;
         wline_q    <= wline_d;
         rline_q    <= rline_d;
         cnt_q      <= cnt_d;
         start_q    <= start_d;
         address_o  <= addr_d;
         burst_o    <= burst_d;
         read_o     <= read_d;
         write_o    <= write_d;
         resp_o     <= resp_d;
         busy_o     <= busy_d;
      end
   end

endmodule

// File: tb/tb_burst_line_adaptor.sv
// Bench for burst_line_adaptor: a 256/64 instance is checked against a
// transaction-level model on every cycle. A 512/128 instance runs held-request
// back-to-back reads.
module tb_burst_line_adaptor;

   localparam int unsigned LW = 256, BW = 64, AW = 32, NB = 4;
   localparam int unsigned LW2 = 512, BW2 = 128;
`ifdef CRITICAL_WORD_FIRST_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   localparam logic [LW-1:0] BEATS_A = {64'hAAAA_0003_0000_00A3, 64'hAAAA_0002_0000_00A2,
                                        64'hAAAA_0001_0000_00A1, 64'hAAAA_0000_0000_00A0};
   // Expected line after test 1: slice order depends on beat ordering.
   localparam logic [LW-1:0] LINE_T1_LIN = {64'hAAAA_0003_0000_00A3, 64'hAAAA_0002_0000_00A2,
                                            64'hAAAA_0001_0000_00A1, 64'hAAAA_0000_0000_00A0};
   localparam logic [LW-1:0] LINE_T1_CWF = {64'hAAAA_0001_0000_00A1, 64'hAAAA_0000_0000_00A0,
                                            64'hAAAA_0003_0000_00A3, 64'hAAAA_0002_0000_00A2};
   localparam logic [LW-1:0] LINE_D = {64'hDDDD_0003_0000_00D3, 64'hDDDD_0002_0000_00D2,
                                       64'hDDDD_0001_0000_00D1, 64'hDDDD_0000_0000_00D0};
   localparam logic [LW-1:0] LINE_E = {64'hEEEE_0003_0000_00E3, 64'hEEEE_0002_0000_00E2,
                                       64'hEEEE_0001_0000_00E1, 64'hEEEE_0000_0000_00E0};
   localparam logic [LW-1:0] BEATS_F = {64'hFFFF_0003_0000_00F3, 64'hFFFF_0002_0000_00F2,
                                        64'hFFFF_0001_0000_00F1, 64'hFFFF_0000_0000_00F0};
   localparam logic [LW-1:0] BEATS_G = {64'h6666_0003_0000_0063, 64'h6666_0002_0000_0062,
                                        64'h6666_0001_0000_0061, 64'h6666_0000_0000_0060};

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   logic [LW-1:0] line_i = '0, line_o;
   logic [AW-1:0] address_i = '0, address_o;
   logic          read_i = 1'b0, write_i = 1'b0, resp_o, busy_o;
   logic [BW-1:0] burst_i = '0, burst_o;
   logic          read_o, write_o, resp_i = 1'b0;

   logic [LW2-1:0] b_line_i = '0, b_line_o;
   logic [AW-1:0]  b_address_i = '0, b_address_o;
   logic           b_read_i = 1'b0, b_write_i = 1'b0, b_resp_o, b_busy_o;
   logic [BW2-1:0] b_burst_i = '0, b_burst_o;
   logic           b_read_o, b_write_o, b_resp_i = 1'b0;

   burst_line_adaptor #(.LINE_W(LW), .BURST_W(BW), .ADDR_W(AW)) dut (
      .clk(clk), .reset_n(reset_n), .line_i(line_i), .line_o(line_o),
      .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
      .busy_o(busy_o), .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
      .read_o(read_o), .write_o(write_o), .resp_i(resp_i));

   burst_line_adaptor #(.LINE_W(LW2), .BURST_W(BW2), .ADDR_W(AW)) dut_b (
      .clk(clk), .reset_n(reset_n), .line_i(b_line_i), .line_o(b_line_o),
      .address_i(b_address_i), .read_i(b_read_i), .write_i(b_write_i), .resp_o(b_resp_o),
      .busy_o(b_busy_o), .burst_i(b_burst_i), .burst_o(b_burst_o), .address_o(b_address_o),
      .read_o(b_read_o), .write_o(b_write_o), .resp_i(b_resp_i));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Transaction-level model: phase 0 idle, 1 transferring, 2 completing.
   int                        m_phase = 0, m_acks = 0, m_start = 0;
   bit                        m_op = 1'b0;
   logic [NB-1:0][BW-1:0]     m_wl = '0, m_rl = '0;
   logic [AW-1:0]             m_addr = '0;

   initial forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
         m_phase = 0; m_acks = 0; m_start = 0; m_op = 1'b0;
         m_wl = '0; m_rl = '0; m_addr = '0;
      end else begin
         case (m_phase)
            0: if (write_i || read_i) begin
                  m_op    = write_i;
                  m_wl    = line_i;
                  m_start = CWF ? int'(address_i[4:3]) : 0;
                  m_addr  = CWF ? (address_i & ~32'h7) : (address_i & ~32'h1F);
                  m_acks  = 0;
                  m_phase = 1;
               end
            1: if (resp_i) begin
                  if (!m_op) m_rl[(m_start + m_acks) % NB] = burst_i;
                  m_acks++;
                  if (m_acks == NB) m_phase = 2;
               end
            default: m_phase = 0;
         endcase
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("line_o", line_o, m_rl);
         chk("address_o", address_o, m_addr);
         chk("read_o", read_o, m_phase == 1 && !m_op);
         chk("write_o", write_o, m_phase == 1 && m_op);
         chk("resp_o", resp_o, m_phase == 2);
         chk("busy_o", busy_o, m_phase != 0);
         chk("burst_o", burst_o, (m_phase == 1 && m_op) ? m_wl[(m_start + m_acks) % NB] : '0);
      end
   end

   // Drives one cache request and a reactive memory. gap=0: random acks/data,
   // gap=N: ack every Nth strobe cycle with data from beats. abort_at>0 stops
   // once that many beats have been accepted.
   task automatic run_txn(input bit wr, input bit rd, input logic [AW-1:0] addr,
                          input logic [LW-1:0] line, input int gap,
                          input logic [LW-1:0] beats, input int abort_at,
                          output int strobes, output logic [LW-1:0] seen,
                          output bit got_resp, output bit saw_read);
      int  k, g;
      bit  scrambled;
      k = 0; g = 0; scrambled = 1'b0;
      strobes = 0; seen = '0; got_resp = 1'b0; saw_read = 1'b0;
      write_i = wr; read_i = rd; address_i = addr; line_i = line; resp_i = 1'b0;
      for (int c = 0; c < 200; c++) begin
         step();
         if (abort_at != 0 && k == abort_at) break;
         if (resp_o) begin
            got_resp = 1'b1;
            break;
         end
         if (read_o) saw_read = 1'b1;
         if (read_o || write_o) begin
            if (!scrambled) begin
               line_i    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
               address_i = $urandom;
               scrambled = 1'b1;
            end
            strobes++;
            if (gap == 0) resp_i = ($urandom_range(0, 2) != 0);
            else begin
               g++;
               resp_i = (g == gap);
               if (g == gap) g = 0;
            end
            burst_i = (gap == 0) ? {$urandom, $urandom} : beats[(k % NB) * BW +: BW];
            if (resp_i && k < NB) begin
               seen[k * BW +: BW] = burst_o;
               k++;
            end
         end else begin
            resp_i  = (gap == 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
            burst_i = {$urandom, $urandom};
         end
      end
      read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
   endtask

   int               s;
   logic [LW-1:0]    seen;
   bit               got, sr;
   logic [LW-1:0]    line_t1;
   logic [BW2-1:0]   bb[8];
   int               kb, pulses, rd_cycles, idle_gap;

   initial begin
      line_t1 = CWF ? LINE_T1_CWF : LINE_T1_LIN;

      // Reset state
      reset_n = 1'b0;
      step(); step();
      chk_en = 1'b1;
      chk("rst_line_o", line_o, 0);
      chk("rst_address_o", address_o, 0);
      chk("rst_strobes", {read_o, write_o, resp_o, busy_o}, 0);
      chk("rst_burst_o", burst_o, 0);
      reset_n = 1'b1;
      step();

      // 1: read at 0x1234, ack every cycle
      run_txn(1'b0, 1'b1, 32'h0000_1234, '0, 1, BEATS_A, 0, s, seen, got, sr);
      chk("t1_resp", got, 1);
      chk("t1_read_cycles", s, 4);
      chk("t1_address_o", address_o, CWF ? 32'h0000_1230 : 32'h0000_1220);
      chk("t1_line_o", line_o, line_t1);
      chk("t1_read_low_in_done", read_o, 0);
      step();
      chk("t1_resp_one_cycle", resp_o, 0);

      // 2: write, ack every third cycle
      run_txn(1'b1, 1'b0, 32'h0000_2000, LINE_D, 3, '0, 0, s, seen, got, sr);
      chk("t2_resp", got, 1);
      chk("t2_burst_order", seen, LINE_D);
      chk("t2_write_cycles", s, 12);
      chk("t2_write_low_in_done", write_o, 0);
      chk("t2_line_o_kept", line_o, line_t1);
      step();

      // 3: read and write together -> write only
      run_txn(1'b1, 1'b1, 32'h0000_3000, LINE_E, 1, '0, 0, s, seen, got, sr);
      chk("t3_resp", got, 1);
      chk("t3_burst_order", seen, LINE_E);
      chk("t3_no_read_o", sr, 0);
      chk("t3_line_o_kept", line_o, line_t1);
      step();

      // 4: reset after two read beats, then a clean read
      run_txn(1'b0, 1'b1, 32'h0000_4000, '0, 1, BEATS_F, 2, s, seen, got, sr);
      chk("t4_partial_line", line_o[127:0], BEATS_F[127:0]);
      reset_n = 1'b0;
      #1;
      chk("t4_rst_line_o", line_o, 0);
      chk("t4_rst_outputs", {read_o, write_o, resp_o, busy_o}, 0);
      chk("t4_rst_address_o", address_o, 0);
      step();
      reset_n = 1'b1;
      step();
      chk("t4_no_resp", resp_o, 0);
      run_txn(1'b0, 1'b1, 32'h0000_4020, '0, 1, BEATS_G, 0, s, seen, got, sr);
      chk("t4_resp", got, 1);
      chk("t4_line_o", line_o, BEATS_G);
      chk("t4_address_o", address_o, 32'h0000_4020);
      step();

      // Random traffic: random ops, addresses, lines and ack gaps
      for (int t = 0; t < 60; t++) begin
         int op;
         op = $urandom_range(0, 3);
         run_txn(op >= 2, op != 2, $urandom,
                 {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                 0, '0, 0, s, seen, got, sr);
         chk("rand_resp", got, 1);
         if ($urandom_range(0, 1) == 1) step();
      end
      step();

      // 6: 512/128, request held through DONE -> back-to-back reads
      for (int i = 0; i < 8; i++) bb[i] = {32'hB0B0_0000 + 32'(i), 64'h0, 32'h0000_1000 + 32'(i)};
      kb = 0; pulses = 0; rd_cycles = 0; idle_gap = 0;
      b_read_i = 1'b1;
      b_address_i = 32'h0000_0040;
      for (int c = 0; c < 60; c++) begin
         step();
         if (b_resp_o) begin
            pulses++;
            if (pulses == 1) chk("t6_line_first", b_line_o, {bb[3], bb[2], bb[1], bb[0]});
            if (pulses == 2) begin
               chk("t6_line_second", b_line_o, {bb[7], bb[6], bb[5], bb[4]});
               break;
            end
         end
         if (pulses == 1 && !b_busy_o) idle_gap++;
         if (b_read_o) begin
            rd_cycles++;
            b_resp_i  = 1'b1;
            b_burst_i = bb[kb % 8];
            kb++;
         end else b_resp_i = 1'b0;
      end
      b_read_i = 1'b0;
      b_resp_i = 1'b0;
      chk("t6_resp_pulses", pulses, 2);
      chk("t6_read_cycles", rd_cycles, 8);
      chk("t6_idle_gap", idle_gap, 1);
      chk("t6_address_o", b_address_o, 32'h0000_0040);
      step();
      chk("t6_idle_after", {b_busy_o, b_resp_o, b_read_o}, 0);

      step();
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
